// File: rtl/xadc_scan_ctrl.sv
// xadc_scan_ctrl
//   Multi-channel XADC scan controller. On start it walks the enabled channels
//   in ascending order. For each one it pulses convst, waits for eoc, reads the
//   result over DRP and publishes it on the sample stream and the result bank.
//
//   Optional feature macro: ADC_SCAN_AVG_EN
//     When defined, each channel is converted 2^AVG_LOG2 times and the
//     truncated mean is published. When undefined, one conversion per channel.
//
// Ports
//   clk, reset       system clock (also XADC dclk), synchronous active-high reset
//   start            pulse, begins a scan; dropped while busy
//   continuous       restart automatically after each scan_done
//   ch_mask          enabled channels, latched when a scan starts
//   convst           1-cycle conversion start pulse
//   eoc              end of conversion, asynchronous to clk
//   drp_den          1-cycle DRP read enable
//   drp_daddr        DRP address, valid from den until drdy
//   drp_do           DRP read data; result taken from the top DATA_W bits
//   drp_drdy         DRP data ready
//   busy             scan in progress
//   sample_valid     1-cycle pulse with sample_ch / sample_data
//   sample_ch        channel index of sample_data (held between pulses)
//   sample_data      channel result (held between pulses)
//   result           result bank, channel i at [i*DATA_W +: DATA_W]
//   scan_done        1-cycle pulse at the end of a completed scan
//   timeout_err      sticky; cleared by reset or the next accepted start

module xadc_scan_ctrl #(
    parameter int         NUM_CH       = 4,
    parameter logic [6:0] CH_ADDR_BASE = 7'h1F,
    parameter int         DATA_W       = 12,
    parameter int         TIMEOUT_CYC  = 1023,
    parameter int         AVG_LOG2     = 2
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           start,
    input  logic                                           continuous,
    input  logic [NUM_CH-1:0]                              ch_mask,
    output logic                                           convst,
    input  logic                                           eoc,
    output logic                                           drp_den,
    output logic [6:0]                                     drp_daddr,
    input  logic [15:0]                                    drp_do,
    input  logic                                           drp_drdy,
    output logic                                           busy,
    output logic                                           sample_valid,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] sample_ch,
    output logic [DATA_W-1:0]                              sample_data,
    output logic [NUM_CH*DATA_W-1:0]                       result,
    output logic                                           scan_done,
    output logic                                           timeout_err
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_CONV, S_WAIT_EOC, S_READ, S_WAIT_DRDY, S_STORE, S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_CH-1:0]        mask_q, mask_d;
    logic [CH_W-1:0]          idx_q, idx_d;
    logic [TMR_W-1:0]         timer_q, timer_d;
    logic [DATA_W-1:0]        data_q, data_d;
    logic                     restart_q, restart_d;
    logic                     timeout_err_q, timeout_err_d;
    logic                     sample_valid_q, sample_valid_d;
    logic [CH_W-1:0]          sample_ch_q, sample_ch_d;
    logic [DATA_W-1:0]        sample_data_q, sample_data_d;
    logic [NUM_CH*DATA_W-1:0] result_q, result_d;
    logic                     eoc_s1_q, eoc_s1_d;
    logic                     eoc_s2_q, eoc_s2_d;
    logic                     eoc_s3_q, eoc_s3_d;

`ifdef ADC_SCAN_AVG_EN
    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int SUB_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'((1 << AVG_LOG2) - 1);
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [SUB_W-1:0] sub_q, sub_d;
`endif

    logic            eoc_rise;
    logic            found;
    logic [CH_W-1:0] low_idx;
    logic            unused_drp_bits;

    // Low bits of drp_do below the result field are not used.
    assign unused_drp_bits = ^drp_do;

    assign eoc_rise = eoc_s2_q & ~eoc_s3_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            mask_q         <= '0;
            idx_q          <= '0;
            timer_q        <= '0;
            data_q         <= '0;
            restart_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_ch_q    <= '0;
            sample_data_q  <= '0;
            result_q       <= '0;
            eoc_s1_q       <= 1'b0;
            eoc_s2_q       <= 1'b0;
            eoc_s3_q       <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
            acc_q          <= '0;
            sub_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            mask_q         <= mask_d;
            idx_q          <= idx_d;
            timer_q        <= timer_d;
            data_q         <= data_d;
            restart_q      <= restart_d;
            timeout_err_q  <= timeout_err_d;
            sample_valid_q <= sample_valid_d;
            sample_ch_q    <= sample_ch_d;
            sample_data_q  <= sample_data_d;
            result_q       <= result_d;
            eoc_s1_q       <= eoc_s1_d;
            eoc_s2_q       <= eoc_s2_d;
            eoc_s3_q       <= eoc_s3_d;
`ifdef ADC_SCAN_AVG_EN
            acc_q          <= acc_d;
            sub_q          <= sub_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        idx_d          = idx_q;
        timer_d        = timer_q;
        data_d         = data_q;
        restart_d      = 1'b0;
        timeout_err_d  = timeout_err_q;
        sample_valid_d = 1'b0;
        sample_ch_d    = sample_ch_q;
        sample_data_d  = sample_data_q;
        result_d       = result_q;
        eoc_s1_d       = eoc;
        eoc_s2_d       = eoc_s1_q;
        eoc_s3_d       = eoc_s2_q;
`ifdef ADC_SCAN_AVG_EN
        acc_d          = acc_q;
        sub_d          = sub_q;
`endif
        convst         = 1'b0;
        drp_den        = 1'b0;
        scan_done      = 1'b0;

        // Served channels are cleared from mask_q, so the lowest remaining bit
        // is always the lowest enabled channel at or above the current index.
        found   = 1'b0;
        low_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                found   = 1'b1;
                low_idx = CH_W'(i);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start || restart_q) begin
                    state_d       = S_SEL;
                    mask_d        = ch_mask;
                    idx_d         = '0;
                    timeout_err_d = 1'b0;
                end
            end
            S_SEL: begin
                if (!found) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = low_idx;
                    state_d = S_CONV;
`ifdef ADC_SCAN_AVG_EN
                    acc_d   = '0;
                    sub_d   = '0;
`endif
                end
            end
            S_CONV: begin
                // eoc edges are only acted on in WAIT_EOC, so any edge left
                // over from before this conversion is dropped here.
                convst  = 1'b1;
                timer_d = '0;
                state_d = S_WAIT_EOC;
            end
            S_WAIT_EOC: begin
                if (eoc_rise) begin
                    state_d = S_READ;
                end else if (timer_q == TMR_MAX) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_READ: begin
                drp_den = 1'b1;
                timer_d = '0;
                state_d = S_WAIT_DRDY;
            end
            S_WAIT_DRDY: begin
                if (drp_drdy) begin
`ifdef ADC_SCAN_AVG_EN
                    acc_d = acc_q + ACC_W'(drp_do[15 -: DATA_W]);
                    if (sub_q == SUB_LAST) begin
                        data_d  = acc_d[AVG_LOG2 +: DATA_W];
                        state_d = S_STORE;
                    end else begin
                        sub_d   = sub_q + 1'b1;
                        state_d = S_CONV;
                    end
`else
                    data_d  = drp_do[15 -: DATA_W];
                    state_d = S_STORE;
`endif
                end else if (timer_q == TMR_MAX) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_STORE: begin
                sample_valid_d = 1'b1;
                sample_ch_d    = idx_q;
                sample_data_d  = data_q;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (idx_q == CH_W'(i)) begin
                        mask_d[i]                    = 1'b0;
                        result_d[i*DATA_W +: DATA_W] = data_q;
                    end
                end
                state_d = S_SEL;
            end
            S_DONE: begin
                scan_done = 1'b1;
                restart_d = continuous;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy         = (state_q != S_IDLE);
    assign drp_daddr    = (state_q == S_READ || state_q == S_WAIT_DRDY) ?
                          (CH_ADDR_BASE + 7'(idx_q)) : 7'h00;
    assign sample_valid = sample_valid_q;
    assign sample_ch    = sample_ch_q;
    assign sample_data  = sample_data_q;
    assign result       = result_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_xadc_scan_ctrl.sv
// tb_xadc_scan_ctrl
//   Scoreboard bench for xadc_scan_ctrl. Stimulus pushes the expected samples
//   and DRP addresses of each scan; monitors pop and compare as the DUT
//   presents them. An XADC model answers convst with eoc and den with drdy.
`timescale 1ns/1ps

module tb_xadc_scan_ctrl;

    localparam int         NUM_CH   = 4;
    localparam int         DATA_W   = 12;
    localparam int         TIMEOUT  = 1023;
    localparam int         AVG_LOG2 = 2;
    localparam logic [6:0] BASE     = 7'h1F;
`ifdef ADC_SCAN_AVG_EN
    localparam int NSUB = 1 << AVG_LOG2;
`else
    localparam int NSUB = 1;
`endif

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     start = 1'b0;
    logic                     continuous = 1'b0;
    logic [NUM_CH-1:0]        ch_mask = '0;
    logic                     convst;
    logic                     eoc = 1'b0;
    logic                     drp_den;
    logic [6:0]               drp_daddr;
    logic [15:0]              drp_do = 16'h0;
    logic                     drp_drdy = 1'b0;
    logic                     busy;
    logic                     sample_valid;
    logic [1:0]               sample_ch;
    logic [DATA_W-1:0]        sample_data;
    logic [NUM_CH*DATA_W-1:0] result;
    logic                     scan_done;
    logic                     timeout_err;

    always #5 clk = ~clk;

    xadc_scan_ctrl #(
        .NUM_CH(NUM_CH), .CH_ADDR_BASE(BASE), .DATA_W(DATA_W),
        .TIMEOUT_CYC(TIMEOUT), .AVG_LOG2(AVG_LOG2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .ch_mask(ch_mask), .convst(convst), .eoc(eoc), .drp_den(drp_den),
        .drp_daddr(drp_daddr), .drp_do(drp_do), .drp_drdy(drp_drdy),
        .busy(busy), .sample_valid(sample_valid), .sample_ch(sample_ch),
        .sample_data(sample_data), .result(result), .scan_done(scan_done),
        .timeout_err(timeout_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // DRP read data for read k of address a: base_w + (a<<4) + tab[k].
    logic [15:0] base_w = 16'hABC0;
    logic [15:0] tab [4] = '{16'h0, 16'h0, 16'h0, 16'h0};

    function automatic logic [15:0] word(input logic [6:0] a, input int k);
        return base_w + {5'b0, a, 4'b0} + tab[k % 4];
    endfunction

    typedef struct {
        logic [1:0]        ch;
        logic [DATA_W-1:0] data;
    } samp_t;

    samp_t      exp_q[$];
    logic [6:0] addr_q[$];

    task automatic push_scan(input logic [NUM_CH-1:0] m);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (m[ch]) begin
                logic [6:0]  a;
                logic [15:0] w;
                int          sum;
                samp_t       e;
                a   = BASE + 7'(ch);
                sum = 0;
                for (int k = 0; k < NSUB; k++) begin
                    w = word(a, k);
                    sum += int'(w[15:4]);
                    addr_q.push_back(a);
                end
                e.ch   = 2'(ch);
                e.data = DATA_W'(sum / NSUB);
                exp_q.push_back(e);
            end
        end
    endtask

    // XADC / DRP model, acting just after each rising edge.
    bit         eoc_en = 1'b1;
    int         eoc_lat_fix = 0;
    int         drdy_lat_fix = 0;
    int         eoc_cnt = 0;
    int         eoc_hi = 0;
    int         drdy_cnt = 0;
    int         rd_k = 0;
    logic [6:0] rd_addr = 7'h0;
    logic [6:0] last_addr = 7'h7F;

    always @(posedge clk) begin
        #1;
        drp_drdy = 1'b0;
        drp_do   = 16'($urandom);
        if (reset || !busy || scan_done) begin
            rd_k      = 0;
            last_addr = 7'h7F;
        end
        if (eoc_hi > 0) begin
            eoc_hi--;
            if (eoc_hi == 0) eoc = 1'b0;
        end
        if (eoc_cnt > 0) begin
            eoc_cnt--;
            if (eoc_cnt == 0) begin
                eoc    = 1'b1;
                eoc_hi = 3;
            end
        end
        if (convst && eoc_en)
            eoc_cnt = (eoc_lat_fix > 0) ? eoc_lat_fix : int'($urandom_range(2, 25));
        if (drdy_cnt > 0) begin
            drdy_cnt--;
            if (drdy_cnt == 0) begin
                if (rd_addr != last_addr) rd_k = 0;
                drp_drdy  = 1'b1;
                drp_do    = word(rd_addr, rd_k);
                rd_k++;
                last_addr = rd_addr;
            end
        end
        if (drp_den) begin
            rd_addr  = drp_daddr;
            drdy_cnt = (drdy_lat_fix > 0) ? drdy_lat_fix : int'($urandom_range(1, 5));
        end
    end

    // Monitor: compares every DRP read and sample the DUT presents.
    int conv_seen = 0;
    int done_seen = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (convst) conv_seen++;
            if (scan_done) done_seen++;
            if (drp_den) begin
                if (addr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL den_unexpected: got den at daddr 0x%0h, expected no read", drp_daddr);
                end else begin
                    check("daddr", 64'(drp_daddr), 64'(addr_q.pop_front()));
                end
            end
            if (drp_drdy && busy)
                check("daddr_hold", 64'(drp_daddr), 64'(rd_addr));
            if (sample_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sample_unexpected: got ch %0d data 0x%0h, expected no sample",
                             sample_ch, sample_data);
                end else begin
                    samp_t e;
                    e = exp_q.pop_front();
                    check("sample_ch", 64'(sample_ch), 64'(e.ch));
                    check("sample_data", 64'(sample_data), 64'(e.data));
                    check("result_slice", 64'(result[e.ch*DATA_W +: DATA_W]), 64'(e.data));
                end
            end
        end
    end

    task automatic pulse_start(input logic [NUM_CH-1:0] m);
        ch_mask = m;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!scan_done && n < budget);
        n_checks++;
        if (!scan_done) begin
            n_fail++;
            $display("FAIL %s: got no scan_done within %0d cycles, expected scan_done", name, budget);
        end
    endtask

    task automatic run_scan(input string name, input logic [NUM_CH-1:0] m);
        int c0;
        c0 = conv_seen;
        push_scan(m);
        pulse_start(m);
        wait_done(name, 3000);
        @(negedge clk);
        check({name, "_busy_end"}, 64'(busy), 64'(0));
        check({name, "_convst_count"}, 64'(conv_seen - c0), 64'(NSUB * $countones(m)));
        check({name, "_queue_drained"}, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int d0;
        int n;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_convst", 64'(convst), 64'(0));
        check("rst_den", 64'(drp_den), 64'(0));
        check("rst_daddr", 64'(drp_daddr), 64'(0));
        check("rst_sample_valid", 64'(sample_valid), 64'(0));
        check("rst_scan_done", 64'(scan_done), 64'(0));
        check("rst_timeout_err", 64'(timeout_err), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // Basic scan, fixed latencies.
        base_w       = 16'hABC0;
        tab          = '{16'h0, 16'h0, 16'h0, 16'h0};
        eoc_lat_fix  = 20;
        drdy_lat_fix = 3;
        run_scan("basic", 4'b1011);
        check("basic_ch2_untouched", 64'(result[2*DATA_W +: DATA_W]), 64'(0));
        eoc_lat_fix  = 0;
        drdy_lat_fix = 0;

        // Empty mask: scan_done two cycles after start, no conversions.
        c0 = conv_seen;
        ch_mask = '0;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        check("empty_busy_c1", 64'(busy), 64'(1));
        check("empty_done_c1", 64'(scan_done), 64'(0));
        @(negedge clk);
        check("empty_done_c2", 64'(scan_done), 64'(1));
        @(negedge clk);
        check("empty_busy_c3", 64'(busy), 64'(0));
        check("empty_convst", 64'(conv_seen - c0), 64'(0));

        // Randomized scans.
        for (int i = 0; i < 8; i++) begin
            base_w = 16'($urandom);
            for (int k = 0; k < 4; k++) tab[k] = 16'($urandom);
            run_scan("rand", 4'($urandom));
        end

        // start while busy is dropped.
        base_w = 16'($urandom);
        c0 = conv_seen;
        d0 = done_seen;
        push_scan(4'b0110);
        pulse_start(4'b0110);
        repeat (10) @(negedge clk);
        pulse_start(4'b1111);
        wait_done("busy_start", 3000);
        repeat (40) @(negedge clk);
        check("busy_start_convst", 64'(conv_seen - c0), 64'(2 * NSUB));
        check("busy_start_dones", 64'(done_seen - d0), 64'(1));
        check("busy_start_drained", 64'(exp_q.size()), 64'(0));

        // Timeout: eoc never arrives.
        eoc_en = 1'b0;
        d0 = done_seen;
        pulse_start(4'b0100);
        n = 0;
        while (!convst && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("timeout_convst_seen", 64'(convst), 64'(1));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 2000);
        check("timeout_cycles", 64'(n), 64'(TIMEOUT + 2));
        check("timeout_err_set", 64'(timeout_err), 64'(1));
        repeat (5) @(negedge clk);
        check("timeout_no_done", 64'(done_seen - d0), 64'(0));
        eoc_en = 1'b1;
        base_w = 16'($urandom);
        push_scan(4'b0001);
        pulse_start(4'b0001);
        check("timeout_err_cleared", 64'(timeout_err), 64'(0));
        wait_done("after_timeout", 3000);
        @(negedge clk);
        check("after_timeout_drained", 64'(exp_q.size()), 64'(0));

        // Continuous: three scans, then continuous drops during the third DONE.
        base_w = 16'($urandom);
        for (int k = 0; k < 4; k++) tab[k] = 16'($urandom);
        c0 = conv_seen;
        d0 = done_seen;
        continuous = 1'b1;
        push_scan(4'b0001);
        pulse_start(4'b0001);
        wait_done("cont_1", 3000);
        push_scan(4'b0001);
        wait_done("cont_2", 3000);
        push_scan(4'b0001);
        wait_done("cont_3", 3000);
        continuous = 1'b0;
        repeat (60) @(negedge clk);
        check("cont_busy_end", 64'(busy), 64'(0));
        check("cont_dones", 64'(done_seen - d0), 64'(3));
        check("cont_convst", 64'(conv_seen - c0), 64'(3 * NSUB));
        check("cont_drained", 64'(exp_q.size()), 64'(0));

        // Reset while waiting for drdy; the late drdy must be ignored.
        base_w       = 16'($urandom);
        drdy_lat_fix = 8;
        push_scan(4'b1111);
        pulse_start(4'b1111);
        n = 0;
        while (!drp_den && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midrst_den_seen", 64'(drp_den), 64'(1));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        addr_q.delete();
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_result", 64'(result), 64'(0));
        repeat (20) @(negedge clk);
        check("midrst_busy_late", 64'(busy), 64'(0));
        check("midrst_result_late", 64'(result), 64'(0));
        drdy_lat_fix = 0;

`ifdef ADC_SCAN_AVG_EN
        // Averaging: ch0 samples 0x100,0x101,0x102,0x105 -> 0x102.
        base_w = 16'h1000 - 16'h01F0;
        tab    = '{16'h0000, 16'h0010, 16'h0020, 16'h0050};
        run_scan("avg", 4'b0001);
        check("avg_result", 64'(result[DATA_W-1:0]), 64'h102);
`endif

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
